// File: rtl/rader_frame_capture.sv
// Radar frame capture: synchronizes the ADC sample clock, frames samples between
// rader_pulse strobes and queues them with sof/eof flags in a first-word-fall-through FIFO.
//
//  state     | meaning
//  ----------+-----------------------------------------------
//  S_IDLE    | capture disabled, strobes ignored
//  S_ARMED   | waiting for rader_pulse to start a frame
//  S_CAPTURE | writing one entry per sample strobe until eof
module rader_frame_capture #(
   parameter int DATA_W     = 12,
   parameter int FIFO_DEPTH = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              adc_clk_in,
   input  logic [DATA_W-1:0] adc_data,
   input  logic              rader_pulse,
   input  logic [9:0]        frame_len,
   input  logic              enable,
   output logic [DATA_W-1:0] out_data,
   output logic              out_sof,
   output logic              out_eof,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              overflow,
   output logic              short_frame,
   output logic [15:0]       frame_count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int EW = DATA_W + 2;

   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE} state_t;

   state_t      state_q, state_d;
   logic [9:0]  len_q, len_d;
   logic [9:0]  cnt_q, cnt_d;
   logic [9:0]  eff_len;
   logic [15:0] fcnt_q, fcnt_d;
   logic        short_q, short_d;
   logic        ovf_q, ovf_d;
   logic        wr_req, wr_sof, wr_eof, last;

   logic        sync1_q, sync2_q, hist_q;
   logic [2:0]  prime_q;
   logic        strobe;

   logic [EW-1:0] mem [FIFO_DEPTH];
   logic [AW:0]   wr_ptr_q, rd_ptr_q;
   logic          full, empty, push, pop;
   logic [EW-1:0] head;

   // prime_q masks the strobe until the history flop holds a real input
   // sample, so leaving reset with adc_clk_in high is not seen as an edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         hist_q  <= 1'b0;
         prime_q <= 3'b000;
      end else begin
         sync1_q <= adc_clk_in;
         sync2_q <= sync1_q;
         hist_q  <= sync2_q;
         prime_q <= {prime_q[1:0], 1'b1};
      end
   end

   assign strobe  = sync2_q & ~hist_q & prime_q[2];
   assign eff_len = (frame_len == 10'd0) ? 10'd1 : frame_len;
   assign last    = (cnt_q == len_q - 10'd1);

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      fcnt_d  = fcnt_q;
      short_d = 1'b0;
      wr_req  = 1'b0;
      wr_sof  = 1'b0;
      wr_eof  = 1'b0;
      if (!enable) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: state_d = S_ARMED;
            S_ARMED: begin
               if (rader_pulse) begin
                  len_d   = eff_len;
                  cnt_d   = 10'd0;
                  state_d = S_CAPTURE;
               end
            end
            S_CAPTURE: begin
               if (strobe) begin
                  wr_req = 1'b1;
                  wr_sof = (cnt_q == 10'd0);
                  wr_eof = last;
                  cnt_d  = cnt_q + 10'd1;
                  if (last) begin
                     fcnt_d  = fcnt_q + 16'd1;
                     state_d = S_ARMED;
                  end
               end
               // Same-cycle strobe has already gone to the old frame above.
               if (rader_pulse) begin
                  short_d = ~(strobe & last);
                  len_d   = eff_len;
                  cnt_d   = 10'd0;
                  state_d = S_CAPTURE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign push  = wr_req & ~full;
   assign pop   = ~empty & out_ready;

   always_comb begin
      ovf_d = ovf_q;
      if (!enable)
         ovf_d = 1'b0;
      else if (wr_req && full)
         ovf_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         len_q    <= 10'd1;
         cnt_q    <= 10'd0;
         fcnt_q   <= 16'd0;
         short_q  <= 1'b0;
         ovf_q    <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         fcnt_q  <= fcnt_d;
         short_q <= short_d;
         ovf_q   <= ovf_d;
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q[AW-1:0]] <= {adc_data, wr_sof, wr_eof};
   end

   assign head        = mem[rd_ptr_q[AW-1:0]];
   assign out_valid   = ~empty;
   assign out_data    = out_valid ? head[EW-1:2] : '0;
   assign out_sof     = out_valid & head[1];
   assign out_eof     = out_valid & head[0];
   assign overflow    = ovf_q;
   assign short_frame = short_q;
   assign frame_count = fcnt_q;

endmodule

// File: tb/tb_rader_frame_capture.sv
// Self-checking bench for rader_frame_capture: directed scenarios plus randomized
// frames compared against a frame-level reference model and an output scoreboard.
module tb_rader_frame_capture;

   localparam int DATA_W = 12;
   localparam int DEPTH  = 16;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              adc_clk_in = 1'b0;
   logic [DATA_W-1:0] adc_data = '0;
   logic              rader_pulse = 1'b0;
   logic [9:0]        frame_len = 10'd1;
   logic              enable = 1'b0;
   logic [DATA_W-1:0] out_data;
   logic              out_sof, out_eof, out_valid;
   logic              out_ready = 1'b0;
   logic              overflow, short_frame;
   logic [15:0]       frame_count;

   rader_frame_capture #(.DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .adc_clk_in(adc_clk_in), .adc_data(adc_data),
      .rader_pulse(rader_pulse), .frame_len(frame_len), .enable(enable),
      .out_data(out_data), .out_sof(out_sof), .out_eof(out_eof),
      .out_valid(out_valid), .out_ready(out_ready), .overflow(overflow),
      .short_frame(short_frame), .frame_count(frame_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // frame-level model
   logic [DATA_W+1:0] exp_q[$];
   bit          m_in_frame = 0;
   int          m_len = 1;
   int          m_idx = 0;
   logic [15:0] m_fc = 16'd0;
   bit          m_ovf = 0;

   bit rand_ready = 0;
   bit ready_fixed = 1;
   bit prev_hold = 0;
   logic [DATA_W+1:0] prev_word;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_sample(input logic [DATA_W-1:0] d);
      adc_data   = d;
      adc_clk_in = 1'b1;
      if (m_in_frame && enable) begin
         if (exp_q.size() < DEPTH)
            exp_q.push_back({d, m_idx == 0, m_idx == m_len - 1});
         else
            m_ovf = 1;
         m_idx++;
         if (m_idx == m_len) begin
            m_fc++;
            m_in_frame = 0;
         end
      end
      tick(4);
      adc_clk_in = 1'b0;
      tick(4);
   endtask

   task automatic pulse();
      rader_pulse = 1'b1;
      tick(1);
      rader_pulse = 1'b0;
      check_eq("short_frame", short_frame, m_in_frame);
      m_in_frame = 1;
      m_len = (frame_len == 0) ? 1 : int'(frame_len);
      m_idx = 0;
      tick(1);
      check_eq("short_frame_one_clk", short_frame, 0);
   endtask

   task automatic drain();
      for (int i = 0; i < 400; i++) begin
         if (exp_q.size() == 0 && !out_valid) break;
         tick(1);
      end
      check_eq("drain_model_empty", exp_q.size(), 0);
      check_eq("drain_out_valid", out_valid, 0);
   endtask

   // scoreboard: decide ready for the coming edge, then check what it will pop
   always @(negedge clk) begin
      if (rst) begin
         prev_hold = 0;
         out_ready = ready_fixed;
      end else begin
         if (prev_hold)
            check_eq("hold_stable", {out_data, out_sof, out_eof}, prev_word);
         out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fixed;
         if (out_valid && out_ready) begin
            check_eq("model_nonempty", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               check_eq("pop_entry", {out_data, out_sof, out_eof}, exp_q[0]);
               void'(exp_q.pop_front());
            end
         end
         prev_hold = out_valid && !out_ready;
         prev_word = {out_data, out_sof, out_eof};
      end
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      int len, n;
      tick(3);
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_out_data", out_data, 0);
      check_eq("rst_overflow", overflow, 0);
      check_eq("rst_short", short_frame, 0);
      check_eq("rst_frame_count", frame_count, 0);
      rst = 1'b0;
      enable = 1'b1;
      tick(2);

      // basic 4-sample frame
      frame_len = 10'd4;
      pulse();
      for (int i = 1; i <= 4; i++) send_sample(DATA_W'(i));
      drain();
      check_eq("fc_basic", frame_count, m_fc);

      // frame_len 0 behaves as 1
      frame_len = 10'd0;
      pulse();
      send_sample(12'h005);
      send_sample(12'h006);
      drain();
      check_eq("fc_len0", frame_count, m_fc);

      // aborted frame then full frame
      frame_len = 10'd8;
      pulse();
      for (int i = 0; i < 3; i++) send_sample(12'h100 + DATA_W'(i));
      pulse();
      for (int i = 0; i < 8; i++) send_sample(12'h200 + DATA_W'(i));
      drain();
      check_eq("fc_short", frame_count, m_fc);

      // disable mid-frame: samples afterwards ignored until a new pulse
      frame_len = 10'd5;
      pulse();
      send_sample(12'h301);
      enable = 1'b0;
      m_in_frame = 0;
      m_ovf = 0;
      tick(2);
      enable = 1'b1;
      tick(2);
      send_sample(12'h302);
      drain();
      check_eq("fc_disable", frame_count, m_fc);

      // randomized frames with random backpressure
      rand_ready = 1;
      for (int it = 0; it < 30; it++) begin
         len = $urandom_range(0, 6);
         frame_len = 10'(len);
         pulse();
         if (len == 0) len = 1;
         n = ($urandom_range(0, 3) == 0) ? $urandom_range(1, len) : len;
         for (int k = 0; k < n; k++) send_sample(DATA_W'($urandom_range(0, 4095)));
         tick($urandom_range(0, 5));
         check_eq("fc_random", frame_count, m_fc);
         if ($urandom_range(0, 9) == 0) begin
            enable = 1'b0;
            m_in_frame = 0;
            m_ovf = 0;
            tick(2);
            enable = 1'b1;
            tick(2);
         end
      end
      rand_ready = 0;
      ready_fixed = 1;
      drain();
      check_eq("ovf_random", overflow, m_ovf);

      // overflow with stalled consumer
      ready_fixed = 0;
      frame_len = 10'd20;
      pulse();
      for (int i = 0; i < 20; i++) send_sample(12'h400 + DATA_W'(i));
      check_eq("ovf_set", overflow, m_ovf);
      check_eq("fc_ovf", frame_count, m_fc);
      check_eq("ovf_head_valid", out_valid, 1);
      check_eq("ovf_head", {out_data, out_sof, out_eof}, exp_q[0]);
      tick(10);
      check_eq("ovf_head_later", {out_data, out_sof, out_eof}, exp_q[0]);
      enable = 1'b0;
      m_in_frame = 0;
      m_ovf = 0;
      tick(2);
      check_eq("ovf_cleared", overflow, m_ovf);
      enable = 1'b1;
      ready_fixed = 1;
      drain();

      // reset mid-capture with queued entries, release with adc_clk_in high
      ready_fixed = 0;
      frame_len = 10'd8;
      pulse();
      for (int i = 0; i < 5; i++) send_sample(12'h500 + DATA_W'(i));
      check_eq("pre_rst_valid", out_valid, exp_q.size() != 0);
      adc_clk_in = 1'b1;
      tick(2);
      rst = 1'b1;
      #1;
      exp_q.delete();
      m_fc = 0;
      m_in_frame = 0;
      m_ovf = 0;
      check_eq("rst_mid_valid", out_valid, 0);
      check_eq("rst_mid_data", out_data, 0);
      check_eq("rst_mid_sof", out_sof, 0);
      check_eq("rst_mid_eof", out_eof, 0);
      check_eq("rst_mid_fc", frame_count, m_fc);
      check_eq("rst_mid_ovf", overflow, m_ovf);
      ready_fixed = 1;
      tick(3);
      rst = 1'b0;
      tick(1);
      pulse();
      tick(10);
      check_eq("no_false_strobe", out_valid, 0);
      adc_clk_in = 1'b0;
      tick(4);
      send_sample(12'h6AB);
      drain();
      check_eq("fc_after_rst", frame_count, m_fc);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rader_frame_capture.md
RADER_FRAME_CAPTURE -- requirements
Module: rader_frame_capture

Interface
REQ-001 SHALL have parameter DATA_W, default 12, meaning ADC sample width in bits.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, meaning output FIFO entries (power of two, >=4).
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port adc_clk_in  input  1  ADC sample clock from the clock divider, asynchronous to clk.
REQ-006 SHALL have port adc_data  input  DATA_W  ADC sample word, stable around adc_clk_in rising edge.
REQ-007 SHALL have port rader_pulse  input  1  one-clk frame-start strobe, clk domain.
REQ-008 SHALL have port frame_len  input  10  samples per frame; 0 treated as 1.
REQ-009 SHALL have port enable  input  1  capture enable, level.
REQ-010 SHALL have port out_data  output  DATA_W  sample at FIFO head.
REQ-011 SHALL have port out_sof  output  1  head sample is first of frame.
REQ-012 SHALL have port out_eof  output  1  head sample is last of frame.
REQ-013 SHALL have port out_valid  output  1  head entry valid.
REQ-014 SHALL have port out_ready  input  1  consumer accepts head when out_valid high.
REQ-015 SHALL have port overflow  output  1  sticky: a sample was dropped on full FIFO.
REQ-016 SHALL have port short_frame  output  1  one-clk pulse: frame aborted by new rader_pulse.
REQ-017 SHALL have port frame_count  output  16  completed frames (eof written), wraps 0xFFFF->0.

Function
REQ-018 SHALL pass adc_clk_in through a 2-flop synchronizer plus one history flop; sample strobe = stage2 & !stage3, exactly one clk, 3 clk after the adc_clk_in rise is registered.
REQ-019 SHALL capture adc_data into a register on the strobe cycle.
REQ-020 SHALL implement FSM IDLE, ARMED, CAPTURE; IDLE->ARMED when enable=1; any state->IDLE on the cycle after enable=0.
REQ-021 ARMED->CAPTURE on rader_pulse: latch frame_len (0->1), clear sample counter; a strobe in that same cycle SHALL be discarded.
REQ-022 In CAPTURE each strobe SHALL write {sample, sof=(count==0), eof=(count==len-1)} and increment count; after the eof write -> ARMED.
REQ-023 rader_pulse in CAPTURE with count<len SHALL pulse short_frame, relatch frame_len, clear count, stay CAPTURE; a strobe in that cycle SHALL be written to the old frame first (if it is that frame's eof, no short_frame).
REQ-024 Strobes in IDLE or ARMED SHALL be ignored.
REQ-025 Write on full FIFO SHALL drop the entry, set overflow, still advance count and FSM; full is evaluated before a same-cycle read.
REQ-026 overflow SHALL clear only on rst or while enable=0.
REQ-027 FIFO SHALL be first-word-fall-through: an entry written to an empty FIFO shows out_valid=1 on the next clk; pop on out_valid & out_ready.
REQ-028 out_data/out_sof/out_eof SHALL hold stable while out_valid=1 and out_ready=0.
REQ-029 frame_count SHALL increment when an eof entry is written (also when the eof entry is dropped).
REQ-030 enable=0 SHALL stop writes but let the FIFO drain normally.

Reset
REQ-031 On rst: FSM=IDLE, FIFO empty, out_valid=0, out_data=0, out_sof=0, out_eof=0, overflow=0, short_frame=0, frame_count=0, synchronizer flops=0.
REQ-032 Release of rst SHALL produce no strobe even if adc_clk_in=1 (no false edge).

Verification
REQ-033 enable=1, frame_len=4, rader_pulse, 4 adc_clk_in rises (data 1..4), out_ready=1 -> outputs 1(sof),2,3,4(eof); frame_count=1.
REQ-034 frame_len=0, pulse, 2 rises -> single entry with sof=eof=1, second sample ignored, FSM back in ARMED.
REQ-035 frame_len=8, pulse, 3 samples, pulse -> short_frame single pulse, next sample has sof=1, frame_count unchanged.
REQ-036 out_ready=0, FIFO_DEPTH=16, frame_len=20, 20 rises -> 16 entries kept, overflow=1, frame_count=1, head data stable.
REQ-037 rst asserted mid-CAPTURE with 5 queued entries -> all outputs zero immediately, no strobe after release with adc_clk_in high.
